masked_serial_adder_ctrl: RTL and testbench

- Bit-serial first-order masked adder sequencer: takes two Boolean-shared WIDTH-bit operands and steps one shared bit pair per slice through a single pg_masked instance.
- Folds each masked propagate/generate pair into a masked ripple carry and returns a Boolean-shared sum and carry-out.
- Sits between the masked-arithmetic front end and the randomness source; it meters fresh random bits with a valid/ready handshake.

---
 rtl/masked_pkg.sv | 14 +
 rtl/pg_masked.sv | 47 ++++
 rtl/masked_serial_adder_ctrl.sv | 138 +++++++++++++
 tb/tb_masked_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/masked_pkg.sv
// Shared types and constants for the first-order masked serial adder.
package masked_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACCUM = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int RND_W     = 2;

endpackage

// File: rtl/pg_masked.sv
// Masked propagate/generate for one Boolean-shared bit pair.
// Outputs are registered, so they are valid one cycle after i_en.
module pg_masked (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_a0,
  input  logic i_a1,
  input  logic i_b0,
  input  logic i_b1,
  input  logic i_r0,
  output logic o_p0,
  output logic o_p1,
  output logic o_g0,
  output logic o_g1
);

  logic w_cross0;
  logic w_cross1;
  logic r_p0, r_p1, r_g0, r_g1;

  // Each cross-domain product is refreshed before it meets the same-domain term.
  assign w_cross0 = (i_a0 & i_b1) ^ i_r0;
  assign w_cross1 = (i_a1 & i_b0) ^ i_r0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0 <= 1'b0;
      r_p1 <= 1'b0;
      r_g0 <= 1'b0;
      r_g1 <= 1'b0;
    end else if (i_en) begin
      r_p0 <= i_a0 ^ i_b0;
      r_p1 <= i_a1 ^ i_b1;
      r_g0 <= (i_a0 & i_b0) ^ w_cross0;
      r_g1 <= (i_a1 & i_b1) ^ w_cross1;
    end
  end

  assign o_p0 = r_p0;
  assign o_p1 = r_p1;
  assign o_g0 = r_g0;
  assign o_g1 = r_g1;

endmodule

// File: rtl/masked_serial_adder_ctrl.sv
// Bit-serial first-order masked adder: one shared bit pair per ISSUE/ACCUM
// slice, rippling a masked carry through a DOM-style AND gadget.
module masked_serial_adder_ctrl
  import masked_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [RND_W-1:0] rnd,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic             cout0,
  output logic             cout1
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a0, r_a1, r_b0, r_b1;
  logic [WIDTH-1:0] r_s0, r_s1;
  logic             r_c0, r_c1, r_c_q;
  logic             r_cout0, r_cout1;
  logic             r_busy, r_done, r_rnd_ready;

  logic w_pg_en;
  logic w_p0, w_p1, w_g0, w_g1;
  logic w_c0_nxt, w_c1_nxt;

  assign w_pg_en = (r_state == ISSUE) && rnd_valid;

  pg_masked u_pg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pg_en),
    .i_a0 (r_a0[r_idx]),
    .i_a1 (r_a1[r_idx]),
    .i_b0 (r_b0[r_idx]),
    .i_b1 (r_b1[r_idx]),
    .i_r0 (rnd[0]),
    .o_p0 (w_p0),
    .o_p1 (w_p1),
    .o_g0 (w_g0),
    .o_g1 (w_g1)
  );

  assign w_c0_nxt = w_g0 ^ (w_p0 & r_c0) ^ ((w_p0 & r_c1) ^ r_c_q);
  assign w_c1_nxt = w_g1 ^ (w_p1 & r_c1) ^ ((w_p1 & r_c0) ^ r_c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a0        <= '0;
      r_a1        <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_s0        <= '0;
      r_s1        <= '0;
      r_c0        <= 1'b0;
      r_c1        <= 1'b0;
      r_c_q       <= 1'b0;
      r_cout0     <= 1'b0;
      r_cout1     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rnd_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a0        <= a0;
            r_a1        <= a1;
            r_b0        <= b0;
            r_b1        <= b1;
            r_c0        <= 1'b0;
            r_c1        <= 1'b0;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_rnd_ready <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (rnd_valid) begin
            r_c_q       <= rnd[1];
            r_rnd_ready <= 1'b0;
            r_state     <= ACCUM;
          end
        end
        ACCUM: begin
          r_s0[r_idx] <= w_p0 ^ r_c0;
          r_s1[r_idx] <= w_p1 ^ r_c1;
          r_c0        <= w_c0_nxt;
          r_c1        <= w_c1_nxt;
          if (r_idx == LAST_IDX) begin
            // Carry-out lands together with the last sum bit so that all
            // results are already stable while done is high in FIN.
            r_cout0 <= w_c0_nxt;
            r_cout1 <= w_c1_nxt;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_idx       <= r_idx + 1'b1;
            r_rnd_ready <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rnd_ready = r_rnd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign s0        = r_s0;
  assign s1        = r_s1;
  assign cout0     = r_cout0;
  assign cout1     = r_cout1;

endmodule

// File: tb/tb_masked_serial_adder_ctrl.sv
// Directed, table-driven bench for masked_serial_adder_ctrl (WIDTH=8).
module tb_masked_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a0, a1, b0, b1;
  logic [1:0]   rnd;
  logic         rnd_valid;
  logic         rnd_ready, busy, done;
  logic [W-1:0] s0, s1;
  logic         cout0, cout1;

  int n_checks = 0;
  int n_pass   = 0;

  masked_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .busy      (busy),
    .done      (done),
    .s0        (s0),
    .s1        (s1),
    .cout0     (cout0),
    .cout1     (cout1)
  );

  always #5 clk = ~clk;

  // mode: 0 = rnd all zero, 1 = random, 2 = constant 2'b10
  typedef struct {
    logic [W-1:0] a0, a1, b0, b1;
    int           mode;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] pick_rnd(input int mode);
    if (mode == 0) return 2'b00;
    if (mode == 2) return 2'b10;
    return 2'($urandom_range(0, 3));
  endfunction

  // Launches one operation and observes it at negedges until a few cycles
  // past done (or a 60-cycle budget). Cycle n is the one following the n-th
  // rising edge after start is raised.
  task automatic run_op(input logic [W-1:0] ia0, ia1, ib0, ib1,
                        input int mode, stall_bit, stall_len, restart_at,
                        output int lat, output logic [W-1:0] os0, os1,
                        output logic oc0, oc1,
                        output int rdy_cnt, hs, pulses, busy_cnt);
    int cycle;
    int stall_left;
    lat = 0; os0 = '0; os1 = '0; oc0 = 1'b0; oc1 = 1'b0;
    rdy_cnt = 0; hs = 0; pulses = 0; busy_cnt = 0;
    stall_left = stall_len;
    cycle = 0;
    @(negedge clk);
    a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
    start = 1'b1;
    rnd_valid = 1'b1;
    rnd = pick_rnd(mode);
    while (cycle < 60 && !(lat != 0 && cycle >= lat + 3)) begin
      @(posedge clk);
      cycle++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (rnd_ready) rdy_cnt++;
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = cycle; os0 = s0; os1 = s1; oc0 = cout0; oc1 = cout1;
        end
      end
      start = (cycle == restart_at);
      a0 = ~ia0; a1 = ia1 ^ 8'h5A; b0 = ~ib0; b1 = ib1 ^ 8'hA5;
      if (rnd_ready && hs == stall_bit && stall_left > 0) begin
        rnd_valid = 1'b0;
        stall_left--;
      end else begin
        rnd_valid = 1'b1;
      end
      rnd = pick_rnd(mode);
      if (rnd_ready && rnd_valid) hs++;
    end
    start = 1'b0;
    rnd_valid = 1'b0;
  endtask

  initial begin
    int lat, rdy, hs, pulses, bcnt, dcnt;
    logic [W-1:0] rs0, rs1, first_s0;
    logic rc0, rc1;

    vecs[0] = '{8'h3C, 8'h66, 8'h0F, 8'hCC, 1, 8'h1D, 1'b1}; // 5A + C3
    vecs[1] = '{8'hAA, 8'h55, 8'h01, 8'h00, 1, 8'h00, 1'b1}; // FF + 01
    vecs[2] = '{8'h5A, 8'h5A, 8'h33, 8'h33, 1, 8'h00, 1'b0}; // 00 + 00
    vecs[3] = '{8'h12, 8'h6D, 8'hF0, 8'hF1, 1, 8'h80, 1'b0}; // 7F + 01
    vecs[4] = '{8'h0F, 8'hF0, 8'hFF, 8'h00, 0, 8'hFE, 1'b1}; // FF + FF, rnd=0
    vecs[5] = '{8'h80, 8'h00, 8'hC0, 8'h40, 2, 8'h00, 1'b1}; // 80 + 80

    rst = 1'b1; start = 1'b0; rnd = '0; rnd_valid = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy",      busy,      0);
    check("reset done",      done,      0);
    check("reset rnd_ready", rnd_ready, 0);
    check("reset s0",        s0,        0);
    check("reset s1",        s1,        0);
    check("reset cout0",     cout0,     0);
    check("reset cout1",     cout1,     0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1, vecs[i].mode, -1, 0, -1,
             lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
      check($sformatf("vec%0d latency", i),   lat,       17);
      check($sformatf("vec%0d sum", i),       rs0 ^ rs1, vecs[i].sum);
      check($sformatf("vec%0d cout", i),      rc0 ^ rc1, vecs[i].cout);
      check($sformatf("vec%0d done pulses", i), pulses,  1);
      check($sformatf("vec%0d busy cycles", i), bcnt,    17);
      check($sformatf("vec%0d ready cycles", i), rdy,    8);
    end

    // Three-cycle randomness stall in the ISSUE slot of bit 4.
    run_op(8'h3C, 8'h66, 8'h0F, 8'hCC, 1, 4, 3, -1,
           lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
    check("stall latency",      lat,       20);
    check("stall sum",          rs0 ^ rs1, 8'h1D);
    check("stall cout",         rc0 ^ rc1, 1);
    check("stall ready cycles", rdy,       11);
    check("stall handshakes",   hs,        8);
    check("stall busy cycles",  bcnt,      20);

    // Same operands, two fixed rnd streams: same value, different shares.
    run_op(8'h3C, 8'h66, 8'h0F, 8'hCC, 0, -1, 0, -1,
           lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
    first_s0 = rs0;
    check("rnd0 sum",  rs0 ^ rs1, 8'h1D);
    check("rnd0 cout", rc0 ^ rc1, 1);
    run_op(8'h3C, 8'h66, 8'h0F, 8'hCC, 2, -1, 0, -1,
           lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
    check("rnd2 sum",           rs0 ^ rs1,        8'h1D);
    check("rnd2 cout",          rc0 ^ rc1,        1);
    check("share s0 differs",   rs0 != first_s0,  1);

    // start re-pulsed mid-operation (with different operands) is ignored.
    run_op(8'h3C, 8'h66, 8'h0F, 8'hCC, 1, -1, 0, 5,
           lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
    check("restart latency",     lat,       17);
    check("restart done pulses", pulses,    1);
    check("restart sum",         rs0 ^ rs1, 8'h1D);
    check("restart cout",        rc0 ^ rc1, 1);

    // Asynchronous reset at cycle 9 of an operation.
    @(negedge clk);
    a0 = 8'h3C; a1 = 8'h66; b0 = 8'h0F; b1 = 8'hCC;
    start = 1'b1; rnd_valid = 1'b1; rnd = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      @(negedge clk);
      rnd = 2'($urandom_range(0, 3));
    end
    rst = 1'b1;
    #1;
    check("midrst busy",      busy,      0);
    check("midrst done",      done,      0);
    check("midrst rnd_ready", rnd_ready, 0);
    check("midrst s0",        s0,        0);
    check("midrst s1",        s1,        0);
    check("midrst cout0",     cout0,     0);
    check("midrst cout1",     cout1,     0);
    dcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst no done", dcnt, 0);
    run_op(8'h3C, 8'h66, 8'h0F, 8'hCC, 1, -1, 0, -1,
           lat, rs0, rs1, rc0, rc1, rdy, hs, pulses, bcnt);
    check("post-rst latency", lat,       17);
    check("post-rst sum",     rs0 ^ rs1, 8'h1D);
    check("post-rst cout",    rc0 ^ rc1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
